// File: rtl/w_residue_pkg.sv
// Shared types and helpers for the signed-digit residue bank.
// Optional feature macro used by the bank: W_RES_NORM_EN.
package w_residue_pkg;

  typedef enum logic {CLEAR = 1'b0, READY = 1'b1} w_state_e;

  localparam int W_ADDR_WIDTH = 7;
  localparam int DEPTH        = 2**W_ADDR_WIDTH;

  // Bit offset of lane k inside a packed multi-lane data bus.
  function automatic int lane_off(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/w_residue_lane.sv
// One residue lane: plus/minus arrays, write-first bypass and read register.
// W_RES_NORM_EN defined: stored digits are normalised (coincident +1/-1 cancel).
module w_residue_lane
  import w_residue_pkg::*;
#(
  parameter int UNROLLING  = 64,
  parameter int ADDR_WIDTH = W_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [UNROLLING-1:0]  wplus_i,
  input  logic [UNROLLING-1:0]  wminus_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [UNROLLING-1:0]  rplus_o,
  output logic [UNROLLING-1:0]  rminus_o
);

  localparam int LDEPTH = 2**ADDR_WIDTH;

  logic [UNROLLING-1:0] plus_mem  [LDEPTH];
  logic [UNROLLING-1:0] minus_mem [LDEPTH];
  logic [UNROLLING-1:0] nplus, nminus;
  logic [UNROLLING-1:0] rplus_q, rminus_q, rplus_d, rminus_d;
  logic                 hit;

`ifdef W_RES_NORM_EN
  assign nplus  = wplus_i & ~wminus_i;
  assign nminus = wminus_i & ~wplus_i;
`else
  assign nplus  = wplus_i;
  assign nminus = wminus_i;
`endif

  // Arrays carry no reset so they can map onto RAM; the clear sweep zeroes them.
  always_ff @(posedge clk) begin
    if (we_i) begin
      plus_mem[waddr_i]  <= nplus;
      minus_mem[waddr_i] <= nminus;
    end
  end

  assign hit      = we_i && (waddr_i == raddr_i);
  assign rplus_d  = hit ? nplus  : plus_mem[raddr_i];
  assign rminus_d = hit ? nminus : minus_mem[raddr_i];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rplus_q  <= '0;
      rminus_q <= '0;
    end else if (re_i) begin
      rplus_q  <= rplus_d;
      rminus_q <= rminus_d;
    end
  end

  assign rplus_o  = rplus_q;
  assign rminus_o = rminus_q;

endmodule

// File: rtl/w_residue_bank.sv
// Multi-lane residue bank: clear-sweep FSM, sweep counter, rd_valid and lane muxing.
// Optional normalisation of stored digits is enabled with W_RES_NORM_EN.
module w_residue_bank
  import w_residue_pkg::*;
#(
  parameter int UNROLLING  = 64,
  parameter int ADDR_WIDTH = W_ADDR_WIDTH,
  parameter int LANES      = 2
) (
  input  logic                       clk,
  input  logic                       asyn_reset,
  input  logic                       enable,
  input  logic                       clr_req,
  output logic                       busy,
  input  logic [LANES-1:0]           wr_en,
  input  logic [ADDR_WIDTH-1:0]      wr_addr,
  input  logic [LANES*UNROLLING-1:0] wr_plus,
  input  logic [LANES*UNROLLING-1:0] wr_minus,
  input  logic                       rd_en,
  input  logic [ADDR_WIDTH-1:0]      rd_addr,
  output logic [LANES*UNROLLING-1:0] rd_plus,
  output logic [LANES*UNROLLING-1:0] rd_minus,
  output logic                       rd_valid
);

  w_state_e              state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  clearing, ready, rd_fire;
  logic [ADDR_WIDTH-1:0] lane_addr;

  assign clearing  = (state_q == CLEAR) && enable;
  assign ready     = (state_q == READY);
  assign rd_fire   = ready && enable && rd_en;
  assign lane_addr = (state_q == CLEAR) ? cnt_q : wr_addr;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rd_valid_d = rd_fire;
    case (state_q)
      CLEAR: if (enable) begin
        if (cnt_q == '1) state_d = READY;
        else             cnt_d   = cnt_q + 1'b1;
      end
      READY: if (enable && clr_req) begin
        state_d = CLEAR;
        cnt_d   = '0;
      end
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge clk or posedge asyn_reset) begin
    if (asyn_reset) begin
      state_q    <= CLEAR;
      cnt_q      <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign busy     = (state_q == CLEAR);
  assign rd_valid = rd_valid_q;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    localparam int OFF = lane_off(k, UNROLLING);
    logic                 we;
    logic [UNROLLING-1:0] wp, wm;

    // During the sweep every lane writes zero at the counter address.
    assign we = clearing || (ready && enable && wr_en[k]);
    assign wp = (state_q == CLEAR) ? '0 : wr_plus[OFF +: UNROLLING];
    assign wm = (state_q == CLEAR) ? '0 : wr_minus[OFF +: UNROLLING];

    w_residue_lane #(.UNROLLING(UNROLLING), .ADDR_WIDTH(ADDR_WIDTH)) u_lane (
      .clk      (clk),
      .rst      (asyn_reset),
      .we_i     (we),
      .waddr_i  (lane_addr),
      .wplus_i  (wp),
      .wminus_i (wm),
      .re_i     (rd_fire),
      .raddr_i  (rd_addr),
      .rplus_o  (rd_plus[OFF +: UNROLLING]),
      .rminus_o (rd_minus[OFF +: UNROLLING])
    );
  end

endmodule
